// File: rtl/multi_ch_disp_mux.sv
// multi_ch_disp_mux
//   Registered display-source multiplexer for the 7-segment/LED driver.
//   Picks one of CH channels (data word + blink mask + point mask). Channel 0
//   is the CPU channel, kept in shadow registers loaded on `en`; channels
//   1..CH-1 are live inputs. Modes: manual select, auto-scan with a
//   programmable dwell, and hold (outputs frozen).
//
// Ports
//   clk, rst       : clock, synchronous active-low reset
//   en             : capture slot 0 of the inputs into the CPU shadow
//   mode[1:0]      : 00 manual, 01 auto-scan, 10 hold, 11 manual
//   sel[SW-1:0]    : manual channel select (out-of-range selects channel 0)
//   data_in        : CH*DW channel data, channel k at [k*DW +: DW]
//   les_in         : CH*MW blink masks, same packing
//   point_in       : CH*MW point masks, same packing
//   disp_num       : selected data (registered)
//   le_out         : selected blink mask (registered)
//   point_out      : selected point mask (registered)
//   cur_ch         : channel currently driving the outputs
//   scan_tick      : one-cycle pulse on the first cycle of a new auto channel
module multi_ch_disp_mux #(
    parameter int              CH       = 8,
    parameter int              DW       = 32,
    parameter int              MW       = 8,
    parameter int              SW       = $clog2(CH),
    parameter int              DWELL    = 50_000_000,
    parameter logic [DW-1:0]   RST_DISP = 32'hAA5555AA
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [SW-1:0]    sel,
    input  logic [CH*DW-1:0] data_in,
    input  logic [CH*MW-1:0] les_in,
    input  logic [CH*MW-1:0] point_in,
    output logic [DW-1:0]    disp_num,
    output logic [MW-1:0]    le_out,
    output logic [MW-1:0]    point_out,
    output logic [SW-1:0]    cur_ch,
    output logic             scan_tick
);

    localparam int CW = $clog2(DWELL + 1);

    typedef enum logic [1:0] {
        MODE_MAN  = 2'b00,
        MODE_AUTO = 2'b01,
        MODE_HOLD = 2'b10,
        MODE_MAN3 = 2'b11
    } mode_e;

    logic [DW-1:0] data_ch  [CH];
    logic [MW-1:0] les_ch   [CH];
    logic [MW-1:0] point_ch [CH];

    for (genvar g = 0; g < CH; g++) begin : g_unpack
        assign data_ch[g]  = data_in[g*DW +: DW];
        assign les_ch[g]   = les_in[g*MW +: MW];
        assign point_ch[g] = point_in[g*MW +: MW];
    end

    // Manual select clamp: only needed when CH is not a power of two.
    logic [SW-1:0] man_ch;
    if (CH == (1 << SW)) begin : g_sel_full
        assign man_ch = sel;
    end else begin : g_sel_clamp
        assign man_ch = (sel < SW'(CH)) ? sel : '0;
    end

    logic [DW-1:0] shd_data_q, shd_data_d;
    logic [MW-1:0] shd_le_q,   shd_le_d;
    logic [MW-1:0] shd_pt_q,   shd_pt_d;
    logic [DW-1:0] disp_q,     disp_d;
    logic [MW-1:0] le_q,       le_d;
    logic [MW-1:0] pt_q,       pt_d;
    logic [SW-1:0] cur_q,      cur_d;
    logic          tick_q,     tick_d;
    logic [CW-1:0] cnt_q,      cnt_d;

    logic [SW-1:0] nxt;
    logic          load;

    always_comb begin
        shd_data_d = shd_data_q;
        shd_le_d   = shd_le_q;
        shd_pt_d   = shd_pt_q;
        disp_d     = disp_q;
        le_d       = le_q;
        pt_d       = pt_q;
        cur_d      = cur_q;
        tick_d     = 1'b0;
        cnt_d      = '0;
        nxt        = cur_q;
        load       = 1'b1;

        case (mode_e'(mode))
            MODE_AUTO: begin
                if (cnt_q == CW'(DWELL - 1)) begin
                    tick_d = 1'b1;
                    nxt    = (cur_q == SW'(CH - 1)) ? '0 : cur_q + SW'(1);
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            MODE_HOLD: load = 1'b0;
            default:   nxt  = man_ch;
        endcase

        if (load) begin
            cur_d = nxt;
            // Channel 0 with en=1 takes slot 0 straight from the inputs,
            // which is exactly what the shadow is about to capture.
            if (nxt == '0 && !en) begin
                disp_d = shd_data_q;
                le_d   = shd_le_q;
                pt_d   = shd_pt_q;
            end else begin
                disp_d = data_ch[nxt];
                le_d   = les_ch[nxt];
                pt_d   = point_ch[nxt];
            end
        end

        if (en) begin
            shd_data_d = data_ch[0];
            shd_le_d   = les_ch[0];
            shd_pt_d   = point_ch[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shd_data_q <= RST_DISP;
            shd_le_q   <= '1;
            shd_pt_q   <= '0;
            disp_q     <= RST_DISP;
            le_q       <= '1;
            pt_q       <= '0;
            cur_q      <= '0;
            tick_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            shd_data_q <= shd_data_d;
            shd_le_q   <= shd_le_d;
            shd_pt_q   <= shd_pt_d;
            disp_q     <= disp_d;
            le_q       <= le_d;
            pt_q       <= pt_d;
            cur_q      <= cur_d;
            tick_q     <= tick_d;
            cnt_q      <= cnt_d;
        end
    end

    assign disp_num  = disp_q;
    assign le_out    = le_q;
    assign point_out = pt_q;
    assign cur_ch    = cur_q;
    assign scan_tick = tick_q;

endmodule

// File: tb/tb_multi_ch_disp_mux.sv
// Bench for multi_ch_disp_mux: two instances (CH=8/DWELL=4 and CH=6/DWELL=3)
// share control inputs; a behavioural model tracks both and every cycle is
// compared, with directed scenarios layered on top of random traffic.
module tb_multi_ch_disp_mux;

    logic           clk;
    logic           rst;
    logic           en;
    logic [1:0]     mode;
    logic [2:0]     sel;
    logic [8*32-1:0] data_in;
    logic [8*8-1:0]  les_in;
    logic [8*8-1:0]  point_in;

    logic [31:0] d0_disp, d1_disp;
    logic [7:0]  d0_le, d1_le, d0_pt, d1_pt;
    logic [2:0]  d0_cur, d1_cur;
    logic        d0_tick, d1_tick;

    int n_chk  = 0;
    int n_fail = 0;

    multi_ch_disp_mux #(.CH(8), .DW(32), .MW(8), .DWELL(4)) u0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .data_in(data_in), .les_in(les_in), .point_in(point_in),
        .disp_num(d0_disp), .le_out(d0_le), .point_out(d0_pt),
        .cur_ch(d0_cur), .scan_tick(d0_tick)
    );

    multi_ch_disp_mux #(.CH(6), .DW(32), .MW(8), .DWELL(3)) u1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .data_in(data_in[6*32-1:0]), .les_in(les_in[6*8-1:0]), .point_in(point_in[6*8-1:0]),
        .disp_num(d1_disp), .le_out(d1_le), .point_out(d1_pt),
        .cur_ch(d1_cur), .scan_tick(d1_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, one entry per instance.
    logic [31:0] m_shd_d [2];
    logic [7:0]  m_shd_le[2];
    logic [7:0]  m_shd_pt[2];
    logic [31:0] m_disp  [2];
    logic [7:0]  m_le    [2];
    logic [7:0]  m_pt    [2];
    int          m_cur   [2];
    int          m_cnt   [2];
    int          m_tick  [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int ch;
            int dw;
            int n;
            bit ld;
            ch = (i == 0) ? 8 : 6;
            dw = (i == 0) ? 4 : 3;
            if (!rst) begin
                m_shd_d[i]  = 32'hAA5555AA;
                m_shd_le[i] = 8'hFF;
                m_shd_pt[i] = 8'h00;
                m_disp[i]   = 32'hAA5555AA;
                m_le[i]     = 8'hFF;
                m_pt[i]     = 8'h00;
                m_cur[i]    = 0;
                m_cnt[i]    = 0;
                m_tick[i]   = 0;
            end else begin
                ld        = 1;
                m_tick[i] = 0;
                n         = m_cur[i];
                if (mode == 2'b01) begin
                    if (m_cnt[i] == dw - 1) begin
                        m_cnt[i]  = 0;
                        n         = (m_cur[i] + 1) % ch;
                        m_tick[i] = 1;
                    end else begin
                        m_cnt[i]++;
                    end
                end else if (mode == 2'b10) begin
                    m_cnt[i] = 0;
                    ld       = 0;
                end else begin
                    m_cnt[i] = 0;
                    n        = (int'(sel) < ch) ? int'(sel) : 0;
                end
                if (ld) begin
                    m_cur[i] = n;
                    if (n == 0 && !en) begin
                        m_disp[i] = m_shd_d[i];
                        m_le[i]   = m_shd_le[i];
                        m_pt[i]   = m_shd_pt[i];
                    end else begin
                        m_disp[i] = data_in[n*32 +: 32];
                        m_le[i]   = les_in[n*8 +: 8];
                        m_pt[i]   = point_in[n*8 +: 8];
                    end
                end
                if (en) begin
                    m_shd_d[i]  = data_in[31:0];
                    m_shd_le[i] = les_in[7:0];
                    m_shd_pt[i] = point_in[7:0];
                end
            end
        end
    endtask

    // One clock: advance the model at the edge, compare at the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("u0 disp", d0_disp, m_disp[0]);
        chk("u0 le",   {24'h0, d0_le},  {24'h0, m_le[0]});
        chk("u0 pt",   {24'h0, d0_pt},  {24'h0, m_pt[0]});
        chk("u0 cur",  {29'h0, d0_cur}, 32'(m_cur[0]));
        chk("u0 tick", {31'h0, d0_tick}, 32'(m_tick[0]));
        chk("u1 disp", d1_disp, m_disp[1]);
        chk("u1 le",   {24'h0, d1_le},  {24'h0, m_le[1]});
        chk("u1 pt",   {24'h0, d1_pt},  {24'h0, m_pt[1]});
        chk("u1 cur",  {29'h0, d1_cur}, 32'(m_cur[1]));
        chk("u1 tick", {31'h0, d1_tick}, 32'(m_tick[1]));
    endtask

    task automatic rnd_inputs();
        for (int k = 0; k < 8; k++) begin
            data_in[k*32 +: 32] = $urandom;
            les_in[k*8 +: 8]    = 8'($urandom);
            point_in[k*8 +: 8]  = 8'($urandom);
        end
    endtask

    initial begin
        int ticks;
        int wrap;
        int prev;
        int first;

        rst  = 1'b0;
        en   = 1'b0;
        mode = 2'b00;
        sel  = 3'd0;
        rnd_inputs();

        // Reset held two cycles, then released in manual/sel=0.
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        chk("rst disp", d0_disp, 32'hAA5555AA);
        chk("rst le",   {24'h0, d0_le}, 32'hFF);
        chk("rst pt",   {24'h0, d0_pt}, 32'h00);
        chk("rst cur",  {29'h0, d0_cur}, 32'd0);

        // Manual select, one-cycle latency.
        data_in[3*32 +: 32] = 32'h33333333;
        sel = 3'd3;
        cyc();
        chk("man disp", d0_disp, 32'h33333333);
        chk("man cur",  {29'h0, d0_cur}, 32'd3);

        // Out-of-range select on the 6-channel instance falls back to 0.
        sel = 3'd7;
        cyc();
        chk("oob cur",  {29'h0, d1_cur}, 32'd0);
        chk("oob disp", d1_disp, 32'hAA5555AA);

        // CPU write forwarded when channel 0 is selected, then persists.
        sel = 3'd0;
        en  = 1'b1;
        data_in[31:0] = 32'h12345678;
        les_in[7:0]   = 8'h0F;
        cyc();
        chk("fwd disp", d0_disp, 32'h12345678);
        chk("fwd le",   {24'h0, d0_le}, 32'h0F);
        en = 1'b0;
        repeat (3) begin
            data_in[31:0] = $urandom;
            les_in[7:0]   = 8'($urandom);
            cyc();
        end
        chk("fwd keep", d0_disp, 32'h12345678);
        chk("fwd keep le", {24'h0, d0_le}, 32'h0F);

        // Auto-scan across a full wrap.
        mode  = 2'b01;
        ticks = 0;
        wrap  = 0;
        prev  = int'(d0_cur);
        repeat (36) begin
            rnd_inputs();
            cyc();
            if (d0_tick) ticks++;
            if (prev == 7 && d0_cur == 3'd0) wrap = 1;
            prev = int'(d0_cur);
        end
        chk("auto ticks", 32'(ticks), 32'd9);
        chk("auto wrap",  32'(wrap),  32'd1);

        // Hold at channel 2 while toggling en.
        for (int k = 0; k < 20 && d0_cur != 3'd2; k++) cyc();
        chk("reach ch2", {29'h0, d0_cur}, 32'd2);
        mode = 2'b10;
        repeat (20) begin
            en = 1'($urandom);
            rnd_inputs();
            cyc();
            chk("hold cur",  {29'h0, d0_cur}, 32'd2);
            chk("hold tick", {31'h0, d0_tick}, 32'd0);
        end
        en    = 1'b0;
        mode  = 2'b01;
        first = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (d0_tick && first == 0) first = k;
        end
        chk("resume dwell", 32'(first), 32'd4);

        // Reset mid-scan with a competing CPU write.
        for (int k = 0; k < 40 && d0_cur != 3'd5; k++) cyc();
        chk("reach ch5", {29'h0, d0_cur}, 32'd5);
        rst = 1'b0;
        en  = 1'b1;
        rnd_inputs();
        cyc();
        chk("mid rst disp", d0_disp, 32'hAA5555AA);
        chk("mid rst cur",  {29'h0, d0_cur}, 32'd0);
        chk("mid rst le",   {24'h0, d0_le}, 32'hFF);
        rst  = 1'b1;
        en   = 1'b0;
        mode = 2'b00;
        sel  = 3'd0;
        cyc();
        chk("shadow rst", d0_disp, 32'hAA5555AA);

        // Random traffic against the model.
        repeat (400) begin
            rst  = (($urandom % 50) != 0);
            en   = (($urandom % 4) == 0);
            mode = 2'($urandom);
            sel  = 3'($urandom);
            rnd_inputs();
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
